// File: rtl/srio_initiator_seg.sv
// SRIO initiator front-end: splits one user command into MAX_PAYLOAD-sized IREQ packets,
// prefetches NWRITE payload from local memory into a small FIFO and tracks doorbell responses.
module srio_initiator_seg #(
    parameter int MAX_PAYLOAD = 256,
    parameter int FIFO_DEPTH  = 16,
    parameter int LEN_W       = 16,
    parameter int MEM_AW      = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [7:0]        cmd_dest_id,
    input  logic [MEM_AW-1:0] cmd_src_addr,
    input  logic [33:0]       cmd_dest_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [15:0]       cmd_db_info,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              mem_rden,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [63:0]       mem_dout,
    output logic              ireq_sof_n,
    output logic              ireq_eof_n,
    output logic              ireq_vld_n,
    input  logic              ireq_rdy_n,
    output logic [63:0]       ireq_data,
    output logic [3:0]        ireq_ftype,
    output logic [3:0]        ireq_ttype,
    output logic [7:0]        ireq_tid,
    output logic [7:0]        ireq_dest_id,
    output logic [33:0]       ireq_addr,
    output logic [8:0]        ireq_byte_count,
    output logic [1:0]        ireq_prio,
    output logic [15:0]       ireq_db_info,
    input  logic              iresp_sof_n,
    input  logic              iresp_eof_n,
    input  logic              iresp_vld_n,
    output logic              iresp_rdy_n,
    input  logic [3:0]        iresp_ftype,
    input  logic [3:0]        iresp_ttype,
    input  logic [3:0]        iresp_status,
    input  logic [7:0]        iresp_tid,
    output logic              busy
);

    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = FA_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [8:0]       MAX_SEG = 9'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [1:0] T_NWRITE = 2'd0;
    localparam logic [1:0] T_NREAD  = 2'd1;
    localparam logic [1:0] T_DB     = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_HDR, S_WR_DATA, S_RD_PKT, S_DB_PKT, S_WAIT_RESP, S_DONE, S_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         type_reg;
    logic [7:0]         dest_id_reg;
    logic [7:0]         tid_reg;
    logic [15:0]        db_info_reg;
    logic [33:0]        addr_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [LEN_W-1:0]   words_reg;
    logic [8:0]         seg_reg;
    logic [5:0]         beat_reg;
    logic [MEM_AW-1:0]  mem_addr_reg;
    logic               inflight_reg;
    logic [CNT_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [TO_W-1:0]    timer_reg;
    logic               inv_err_reg;
    logic [63:0]        fifo_mem [FIFO_DEPTH];

    logic               accept, cmd_invalid, fifo_empty, wr_state, pkt_state;
    logic               xfer, last_beat, end_of_pkt, more, pop, resp_match;
    logic [CNT_W-1:0]   fifo_count, occupancy;
    logic               unused_bits;

    assign unused_bits = ^{cmd_src_addr[2:0], cmd_dest_addr[2:0]};

    assign cmd_ready   = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign cmd_done    = (state_reg == S_DONE);
    assign cmd_err     = (state_reg == S_ERR) || inv_err_reg;
    assign iresp_rdy_n = 1'b0;
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_invalid = (cmd_type == 2'd3) ||
                         ((cmd_type != T_DB) && ((cmd_len == '0) || (cmd_len[2:0] != 3'd0)));

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (fifo_count == '0);
    // Reads already in flight count against capacity so the FIFO can never overflow.
    assign occupancy  = fifo_count + CNT_W'(inflight_reg);
    assign mem_rden   = (words_reg != '0) && (occupancy < DEPTH_C);
    assign mem_addr   = mem_addr_reg;

    assign wr_state   = (state_reg == S_WR_HDR) || (state_reg == S_WR_DATA);
    assign pkt_state  = wr_state || (state_reg == S_RD_PKT) || (state_reg == S_DB_PKT);
    assign xfer       = !ireq_vld_n && !ireq_rdy_n;
    assign last_beat  = (beat_reg == (seg_reg[8:3] - 6'd1));
    assign pop        = xfer && wr_state;
    assign end_of_pkt = xfer && ((wr_state && last_beat) || (state_reg == S_RD_PKT));
    assign more       = (remaining_reg != LEN_W'(seg_reg));
    assign resp_match = !iresp_sof_n && !iresp_eof_n && !iresp_vld_n &&
                        (iresp_ftype == 4'b1101) && (iresp_ttype == 4'b0000) &&
                        (iresp_tid == tid_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (accept && !cmd_invalid) state_next = S_LOAD;
            S_LOAD: begin
                case (type_reg)
                    T_NWRITE: state_next = S_WR_HDR;
                    T_NREAD:  state_next = S_RD_PKT;
                    default:  state_next = S_DB_PKT;
                endcase
            end
            S_WR_HDR, S_WR_DATA: begin
                if (end_of_pkt)  state_next = more ? S_LOAD : S_DONE;
                else if (pop)    state_next = S_WR_DATA;
            end
            S_RD_PKT:    if (end_of_pkt) state_next = more ? S_LOAD : S_DONE;
            S_DB_PKT:    if (xfer) state_next = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (resp_match)               state_next = (iresp_status == 4'd0) ? S_DONE : S_ERR;
                else if (timer_reg == TO_LAST) state_next = S_ERR;
            end
            S_DONE, S_ERR: state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ireq_vld_n      = 1'b1;
        ireq_sof_n      = 1'b1;
        ireq_eof_n      = 1'b1;
        ireq_data       = '0;
        ireq_ftype      = '0;
        ireq_ttype      = '0;
        ireq_tid        = '0;
        ireq_dest_id    = '0;
        ireq_addr       = '0;
        ireq_byte_count = '0;
        ireq_prio       = '0;
        ireq_db_info    = '0;
        if (pkt_state) begin
            case (type_reg)
                T_NWRITE: begin ireq_ftype = 4'b0101; ireq_ttype = 4'b0100; end
                T_NREAD:  begin ireq_ftype = 4'b0010; ireq_ttype = 4'b0100; end
                default:  begin ireq_ftype = 4'b1010; ireq_ttype = 4'b0000; end
            endcase
            ireq_tid        = tid_reg;
            ireq_dest_id    = dest_id_reg;
            ireq_addr       = addr_reg;
            ireq_byte_count = seg_reg;
            ireq_prio       = 2'b01;
            ireq_db_info    = (type_reg == T_DB) ? db_info_reg : 16'd0;
        end
        // Write beats are only offered while the FIFO holds data; framing follows the beat.
        if (wr_state && !fifo_empty) begin
            ireq_vld_n = 1'b0;
            ireq_sof_n = (beat_reg != 6'd0);
            ireq_eof_n = !last_beat;
            ireq_data  = fifo_mem[rd_ptr_reg[FA_W-1:0]];
        end else if ((state_reg == S_RD_PKT) || (state_reg == S_DB_PKT)) begin
            ireq_vld_n = 1'b0;
            ireq_sof_n = 1'b0;
            ireq_eof_n = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (inflight_reg) fifo_mem[wr_ptr_reg[FA_W-1:0]] <= mem_dout;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= S_IDLE;
            type_reg      <= '0;
            dest_id_reg   <= '0;
            tid_reg       <= '0;
            db_info_reg   <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            words_reg     <= '0;
            seg_reg       <= '0;
            beat_reg      <= '0;
            mem_addr_reg  <= '0;
            inflight_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            timer_reg     <= '0;
            inv_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inv_err_reg <= accept && cmd_invalid;
            if (accept && !cmd_invalid) begin
                type_reg      <= cmd_type;
                dest_id_reg   <= cmd_dest_id;
                db_info_reg   <= cmd_db_info;
                addr_reg      <= {cmd_dest_addr[33:3], 3'b000};
                remaining_reg <= (cmd_type == T_DB) ? '0 : cmd_len;
                if (cmd_type == T_NWRITE) begin
                    words_reg    <= cmd_len >> 3;
                    mem_addr_reg <= {cmd_src_addr[MEM_AW-1:3], 3'b000};
                end
            end else if (mem_rden) begin
                words_reg    <= words_reg - 1'b1;
                mem_addr_reg <= mem_addr_reg + MEM_AW'(8);
            end
            if (state_reg == S_LOAD) begin
                tid_reg  <= tid_reg + 8'd1;
                seg_reg  <= (remaining_reg < MAX_LEN) ? remaining_reg[8:0] : MAX_SEG;
                beat_reg <= '0;
            end else if (pop) begin
                beat_reg <= beat_reg + 6'd1;
            end
            if (end_of_pkt) begin
                remaining_reg <= remaining_reg - LEN_W'(seg_reg);
                addr_reg      <= addr_reg + 34'(seg_reg);
            end
            if (state_reg == S_WAIT_RESP) timer_reg <= timer_reg + 1'b1;
            else                          timer_reg <= '0;
            inflight_reg <= mem_rden;
            if (inflight_reg) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: doc/srio_initiator_seg.md
Name: srio_initiator_seg

Overview:
Parametrised SRIO initiator front-end that converts one user command into one or more logical-layer IREQ packets.
- Supported commands: NWRITE from local memory, NREAD request, DOORBELL.
- Commands larger than the maximum payload are split into back-to-back segments. Each segment gets its own TID and its own destination address.
- Write data is prefetched from local memory into an internal FIFO.
- Doorbell responses are matched by TID, with a timeout. The block sits between the user/DMA control logic and the SRIO logical-layer core.

Parameters:
MAX_PAYLOAD, 256, maximum bytes per packet; multiple of 8, range 8..256
FIFO_DEPTH, 16, prefetch FIFO depth in 64-bit words; power of 2, >= 4
LEN_W, 16, width of the total command byte count
MEM_AW, 32, local memory byte-address width
TIMEOUT, 4096, cycles to wait for a doorbell response

Ports:
sys_clk  in  1  single clock
sys_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe; accepted only when cmd_ready=1
cmd_ready  out  1  1 in IDLE
cmd_type  in  2  0=NWRITE, 1=NREAD, 2=DOORBELL, 3=reserved
cmd_dest_id  in  8  destination ID
cmd_src_addr  in  MEM_AW  local memory start byte address; bits[2:0] ignored
cmd_dest_addr  in  34  remote start byte address; bits[2:0] forced to 0
cmd_len  in  LEN_W  total bytes; must be a nonzero multiple of 8 for NWRITE/NREAD
cmd_db_info  in  16  doorbell info
cmd_done  out  1  one-cycle pulse when a command completes
cmd_err  out  1  one-cycle pulse: invalid command, timeout, or nonzero response status
mem_rden  out  1  active-high memory read; data returned on mem_dout 1 cycle later
mem_addr  out  MEM_AW  memory byte address
mem_dout  in  64  memory read data
ireq_sof_n, ireq_eof_n, ireq_vld_n  out  1 each  framing
ireq_rdy_n  in  1  core ready
ireq_data  out  64  payload
ireq_ftype, ireq_ttype  out  4 each  packet type
ireq_tid  out  8  transaction ID
ireq_dest_id  out  8  destination ID
ireq_addr  out  34  segment address
ireq_byte_count  out  9  segment byte count; 256 is encoded as 9'h100
ireq_prio  out  2  constant 2'b01 when active
ireq_db_info  out  16  doorbell info
iresp_sof_n, iresp_eof_n, iresp_vld_n  in  1 each  response framing
iresp_rdy_n  out  1  tied 0
iresp_ftype, iresp_ttype, iresp_status  in  4 each  response fields
iresp_tid  in  8  response TID
busy  out  1  state != IDLE

Behaviour:
Reset values:
- ireq_sof_n/eof_n/vld_n = 1.
- All other ireq_* outputs = 0; ireq_tid = 0.
- mem_rden = 0, mem_addr = 0.
- cmd_done = cmd_err = 0, busy = 0, cmd_ready = 1.
- FIFO is empty.
- Reset mid-packet aborts immediately. No eof is issued after reset.

Command acceptance and validation:
- A command is accepted on cmd_valid & cmd_ready. All fields are latched on that cycle.
- Invalid commands: cmd_type=3; NWRITE/NREAD with cmd_len=0; or cmd_len[2:0]!=0.
- An invalid command gives a cmd_err pulse 1 cycle after acceptance and the block stays in IDLE.

Segmentation:
- seg = min(remaining, MAX_PAYLOAD).
- After each segment: remaining -= seg; segment address += seg; tid += 1 (mod 256, wraps 255->0).

Prefetch (NWRITE only):
- mem_rden is asserted while words_to_read > 0 and (fifo_count + inflight) < FIFO_DEPTH.
- mem_addr starts at cmd_src_addr with bits[2:0] = 0 and steps by 8 per read.
- A word is written to the FIFO the cycle after each mem_rden.
- The FIFO never overflows.

State machine:
- IDLE -> LOAD on a valid command.
- LOAD computes seg, then goes to WR_HDR / RD_PKT / DB_PKT.
- WR_HDR: wait until the FIFO is non-empty, then present the first beat with sof_n=0.
- WR_DATA: one FIFO word per accepted beat. eof_n=0 on beat seg/8.
- RD_PKT / DB_PKT: single beat with sof_n=0 and eof_n=0.
- After an NWRITE or NREAD beat with eof: if remaining > 0 go to LOAD, else go to DONE.
- DB_PKT -> WAIT_RESP.
- WAIT_RESP:
  - Matching response (sof, eof, vld all low; ftype=4'b1101; ttype=0; tid equal to the issued tid): status=0 -> DONE; status!=0 -> ERR.
  - Counter reaches TIMEOUT -> ERR.
  - Non-matching responses are ignored.
- DONE pulses cmd_done and goes to IDLE. ERR pulses cmd_err and goes to IDLE.

Packet types:
- NWRITE: ftype 0101, ttype 0100.
- NREAD: ftype 0010, ttype 0100.
- DOORBELL: ftype 1010, ttype 0000.

IREQ handshake:
- A beat transfers when vld_n=0 and rdy_n=0.
- While vld_n=0 and rdy_n=1, all ireq outputs are held stable.
- Header fields are valid from the sof beat through the eof beat.
- vld_n may deassert between beats only when the FIFO is empty. sof/eof stay aligned to their beats.
- A new packet starts no earlier than the cycle after the previous eof transfer.

Test Plan:
- NWRITE, len=64, MAX_PAYLOAD=256, rdy_n=0 -> one packet of 8 beats; byte_count=64; ftype 0101; tid=1; cmd_done once; 8 mem reads at addresses src..src+56.
- NWRITE, len=600, MAX_PAYLOAD=256 -> 3 packets with byte_count 9'h100, 9'h100, 88; addr dest, dest+256, dest+512; tids 1, 2, 3; a single cmd_done.
- NWRITE, len=256, rdy_n toggling 1/0 every cycle, FIFO_DEPTH=4 -> 32 beats with data in order, fields stable while stalled, FIFO never overflows, eof on beat 32.
- NREAD, len=16 -> one beat with sof=eof=0; ftype 0010; byte_count=16; cmd_done; no mem_rden.
- DOORBELL: matching response (status 0) -> cmd_done. Mismatched tid only -> cmd_err exactly TIMEOUT cycles later. Status=4'b0111 -> cmd_err.
- Invalid command (len=12) -> cmd_err, no ireq activity. Reset asserted mid-WR_DATA -> all outputs at reset values; a subsequent command gives a clean packet with tid=1.
